// File: rtl/aclk_pkg.sv
// Shared types, digit limits and load validity rule for the alarm-clock time counter.
package aclk_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned CLR_CNT_W = 2;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t MAX_HR_MS      = 4'd2;
    localparam bcd_t MAX_HR_LS_AT_2 = 4'd3;
    localparam bcd_t MAX_MIN_MS     = 4'd5;
    localparam bcd_t MAX_DIGIT      = 4'd9;

    typedef enum logic {
        CLR_IDLE,
        CLR_ACTIVE
    } clr_state_e;

    function automatic logic time_valid(
        input bcd_t ms_hr,
        input bcd_t ls_hr,
        input bcd_t ms_min,
        input bcd_t ls_min
    );
        logic hr_ok;
        if (ms_hr < MAX_HR_MS) begin
            hr_ok = (ls_hr <= MAX_DIGIT);
        end else begin
            hr_ok = (ms_hr == MAX_HR_MS) && (ls_hr <= MAX_HR_LS_AT_2);
        end
        return hr_ok && (ms_min <= MAX_MIN_MS) && (ls_min <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/aclk_bcd_digit.sv
// Single BCD digit counter: synchronous load, increment with wrap at a run-time limit, carry-out.
module aclk_bcd_digit
    import aclk_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_en,
    input  logic               load_en,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic [DIGIT_W-1:0] limit,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    bcd_t value_d;
    bcd_t value_q;

    // Wrap on >= so a digit loaded above its limit (unchecked load) still returns to 0.
    always_comb begin
        value_d = value_q;
        carry   = 1'b0;
        if (load_en) begin
            value_d = load_val;
        end else if (inc_en) begin
            if (value_q >= limit) begin
                value_d = '0;
                carry   = 1'b1;
            end else begin
                value_d = value_q + bcd_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/aclk_timecount.sv
// Time-of-day HH:MM BCD counter driven by one_minute ticks, with user load and tick-generator restart pulse.
module aclk_timecount
    import aclk_pkg::*;
#(
    parameter bit          LOAD_CHECK   = 1'b1,
    parameter int unsigned TICK_CLR_LEN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       reset_count,
    output logic       day_rollover,
    output logic       load_err
);

    localparam logic [CLR_CNT_W-1:0] CLR_LAST = CLR_CNT_W'(TICK_CLR_LEN - 1);

    logic load_ok;
    logic load_acc;
    logic load_rej;
    logic tick_en;

    logic carry_ls_min;
    logic carry_ms_min;
    logic carry_ls_hr;
    logic carry_ms_hr;
    bcd_t hr_ls_limit;

    clr_state_e              state_d, state_q;
    logic [CLR_CNT_W-1:0]    cnt_d, cnt_q;
    logic                    reset_count_d, reset_count_q;
    logic                    day_rollover_d, day_rollover_q;
    logic                    load_err_d, load_err_q;

    assign load_ok  = !LOAD_CHECK || time_valid(new_current_time_ms_hr, new_current_time_ls_hr,
                                                new_current_time_ms_min, new_current_time_ls_min);
    assign load_acc = load_new_c && load_ok;
    assign load_rej = load_new_c && !load_ok;
    // Any load request, valid or not, swallows a coincident tick.
    assign tick_en  = one_minute && !load_new_c;

    assign hr_ls_limit = (current_time_ms_hr == MAX_HR_MS) ? MAX_HR_LS_AT_2 : MAX_DIGIT;

    aclk_bcd_digit u_ls_min (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (tick_en),
        .load_en  (load_acc),
        .load_val (new_current_time_ls_min),
        .limit    (MAX_DIGIT),
        .value    (current_time_ls_min),
        .carry    (carry_ls_min)
    );

    aclk_bcd_digit u_ms_min (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (carry_ls_min),
        .load_en  (load_acc),
        .load_val (new_current_time_ms_min),
        .limit    (MAX_MIN_MS),
        .value    (current_time_ms_min),
        .carry    (carry_ms_min)
    );

    aclk_bcd_digit u_ls_hr (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (carry_ms_min),
        .load_en  (load_acc),
        .load_val (new_current_time_ls_hr),
        .limit    (hr_ls_limit),
        .value    (current_time_ls_hr),
        .carry    (carry_ls_hr)
    );

    aclk_bcd_digit u_ms_hr (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (carry_ls_hr),
        .load_en  (load_acc),
        .load_val (new_current_time_ms_hr),
        .limit    (MAX_HR_MS),
        .value    (current_time_ms_hr),
        .carry    (carry_ms_hr)
    );

    // Stretcher: an accepted load re-arms the full pulse; CLR counts the remaining cycles down to 0.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        reset_count_d  = 1'b0;
        day_rollover_d = carry_ms_hr;
        load_err_d     = load_rej;
        if (load_acc) begin
            state_d       = CLR_ACTIVE;
            cnt_d         = CLR_LAST;
            reset_count_d = 1'b1;
        end else begin
            case (state_q)
                CLR_ACTIVE: begin
                    if (cnt_q == '0) begin
                        state_d = CLR_IDLE;
                    end else begin
                        cnt_d         = cnt_q - 1'b1;
                        reset_count_d = 1'b1;
                    end
                end
                default: begin
                    state_d = CLR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= CLR_IDLE;
            cnt_q          <= '0;
            reset_count_q  <= 1'b0;
            day_rollover_q <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            reset_count_q  <= reset_count_d;
            day_rollover_q <= day_rollover_d;
            load_err_q     <= load_err_d;
        end
    end

    assign reset_count  = reset_count_q;
    assign day_rollover = day_rollover_q;
    assign load_err     = load_err_q;

endmodule

// File: tb/tb_aclk_timecount.sv
// Bench for aclk_timecount: three parameterisations share stimulus and are checked against a minutes-of-day model.
module tb_aclk_timecount;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        one_minute = 1'b0;
    logic        load_new_c = 1'b0;
    logic [15:0] ld = '0;

    logic [15:0] a_t, b_t, c_t;
    logic        a_rc, a_ro, a_er;
    logic        b_rc, b_ro, b_er;
    logic        c_rc, c_ro, c_er;

    int          n_err = 0;
    int          n_chk = 0;

    int unsigned ma = 0;
    int unsigned mb = 0;
    int          b_mode = 0;
    logic [15:0] b_raw = '0;
    int          rem_a = 0;
    int          rem_b = 0;
    int          rem_c = 0;
    bit          exp_ro_a = 1'b0;
    bit          exp_err_a = 1'b0;
    bit          exp_ro_b = 1'b0;

    always #5 clk = ~clk;

    aclk_timecount #(.LOAD_CHECK(1'b1), .TICK_CLR_LEN(1)) dut_a (
        .clk                     (clk),
        .reset                   (reset),
        .one_minute              (one_minute),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (ld[15:12]),
        .new_current_time_ls_hr  (ld[11:8]),
        .new_current_time_ms_min (ld[7:4]),
        .new_current_time_ls_min (ld[3:0]),
        .current_time_ms_hr      (a_t[15:12]),
        .current_time_ls_hr      (a_t[11:8]),
        .current_time_ms_min     (a_t[7:4]),
        .current_time_ls_min     (a_t[3:0]),
        .reset_count             (a_rc),
        .day_rollover            (a_ro),
        .load_err                (a_er)
    );

    aclk_timecount #(.LOAD_CHECK(1'b0), .TICK_CLR_LEN(1)) dut_b (
        .clk                     (clk),
        .reset                   (reset),
        .one_minute              (one_minute),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (ld[15:12]),
        .new_current_time_ls_hr  (ld[11:8]),
        .new_current_time_ms_min (ld[7:4]),
        .new_current_time_ls_min (ld[3:0]),
        .current_time_ms_hr      (b_t[15:12]),
        .current_time_ls_hr      (b_t[11:8]),
        .current_time_ms_min     (b_t[7:4]),
        .current_time_ls_min     (b_t[3:0]),
        .reset_count             (b_rc),
        .day_rollover            (b_ro),
        .load_err                (b_er)
    );

    aclk_timecount #(.LOAD_CHECK(1'b1), .TICK_CLR_LEN(3)) dut_c (
        .clk                     (clk),
        .reset                   (reset),
        .one_minute              (one_minute),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (ld[15:12]),
        .new_current_time_ls_hr  (ld[11:8]),
        .new_current_time_ms_min (ld[7:4]),
        .new_current_time_ls_min (ld[3:0]),
        .current_time_ms_hr      (c_t[15:12]),
        .current_time_ls_hr      (c_t[11:8]),
        .current_time_ms_min     (c_t[7:4]),
        .current_time_ls_min     (c_t[3:0]),
        .reset_count             (c_rc),
        .day_rollover            (c_ro),
        .load_err                (c_er)
    );

    function automatic logic [15:0] to_digits(input int unsigned m);
        int unsigned h;
        int unsigned mn;
        h  = m / 60;
        mn = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10)};
    endfunction

    function automatic int unsigned to_minutes(input logic [15:0] d);
        return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic bit legal(input logic [15:0] d);
        int unsigned h;
        int unsigned mn;
        if (d[11:8] > 4'd9 || d[3:0] > 4'd9) return 1'b0;
        h  = int'(d[15:12]) * 10 + int'(d[11:8]);
        mn = int'(d[7:4]) * 10 + int'(d[3:0]);
        return (h < 24) && (mn < 60);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit t, input bit l, input logic [15:0] d);
        bit v;
        reset      = r;
        one_minute = t;
        load_new_c = l;
        ld         = d;
        v          = legal(d);
        exp_ro_a   = 1'b0;
        exp_err_a  = 1'b0;
        exp_ro_b   = 1'b0;
        if (!r) begin
            ma = 0; mb = 0; b_mode = 0;
            rem_a = 0; rem_b = 0; rem_c = 0;
        end else begin
            rem_a = (rem_a > 0) ? rem_a - 1 : 0;
            rem_b = (rem_b > 0) ? rem_b - 1 : 0;
            rem_c = (rem_c > 0) ? rem_c - 1 : 0;
            if (l) begin
                if (v) begin
                    ma = to_minutes(d);
                    rem_a = 1;
                    rem_c = 3;
                end else begin
                    exp_err_a = 1'b1;
                end
                rem_b = 1;
                if (v) begin
                    mb = to_minutes(d);
                    b_mode = 0;
                end else begin
                    b_raw = d;
                    b_mode = 1;
                end
            end else if (t) begin
                exp_ro_a = (ma == 1439);
                ma = (ma + 1) % 1440;
                if (b_mode == 0) begin
                    exp_ro_b = (mb == 1439);
                    mb = (mb + 1) % 1440;
                end else begin
                    b_mode = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("a_time", a_t, to_digits(ma));
        chk("a_reset_count", 16'(a_rc), 16'(rem_a > 0));
        chk("a_day_rollover", 16'(a_ro), 16'(exp_ro_a));
        chk("a_load_err", 16'(a_er), 16'(exp_err_a));
        chk("c_time", c_t, to_digits(ma));
        chk("c_reset_count", 16'(c_rc), 16'(rem_c > 0));
        chk("c_day_rollover", 16'(c_ro), 16'(exp_ro_a));
        chk("c_load_err", 16'(c_er), 16'(exp_err_a));
        if (b_mode == 0) begin
            chk("b_time", b_t, to_digits(mb));
            chk("b_day_rollover", 16'(b_ro), 16'(exp_ro_b));
        end else if (b_mode == 1) begin
            chk("b_time_raw", b_t, b_raw);
        end
        chk("b_reset_count", 16'(b_rc), 16'(rem_b > 0));
        chk("b_load_err", 16'(b_er), 16'h0000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        bit          r_r, r_t, r_l;
        logic [15:0] r_d;

        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        idle(1);

        cycle(1'b1, 1'b0, 1'b1, 16'h1258);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        idle(9);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        idle(2);

        cycle(1'b1, 1'b0, 1'b1, 16'h2359);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        idle(1);

        cycle(1'b1, 1'b0, 1'b1, 16'h2400);
        idle(1);
        cycle(1'b1, 1'b0, 1'b1, 16'h0960);
        idle(2);

        cycle(1'b1, 1'b0, 1'b1, 16'h0729);
        idle(1);
        cycle(1'b1, 1'b1, 1'b1, 16'h0730);
        idle(2);

        cycle(1'b1, 1'b0, 1'b1, 16'h1015);
        cycle(1'b1, 1'b0, 1'b1, 16'h1015);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        idle(3);

        for (int k = 0; k < 600; k++) begin
            r_r = ($urandom_range(0, 59) != 0);
            r_t = ($urandom_range(0, 2) == 0);
            r_l = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0:       r_d = to_digits($urandom_range(0, 1439));
                1:       r_d = to_digits($urandom_range(1430, 1439));
                default: r_d = 16'($urandom);
            endcase
            cycle(r_r, r_t, r_l, r_d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aclk_timecount.md
Name: aclk_timecount

Overview:
- Consumer end of the one_min tick interface.
- Counts the running time of day as four BCD digits, HH:MM in 24-hour format.
- Accepts a user time load from the key/set path. On each accepted load it drives reset_count back to the minute/second tick generator, so the tick generator restarts its minute window at the loaded time.
- Feeds the display mux and the alarm comparator with current time and a day-rollover pulse.

Parameters:
- LOAD_CHECK, 1, 1 = reject out-of-range load values; 0 = load any value unchecked.
- TICK_CLR_LEN, 1, width in clk cycles of the reset_count pulse; legal range 1..4.

Ports:
- clk  in  1  system clock; same clock as the tick generator.
- reset  in  1  synchronous, active-low reset.
- one_minute  in  1  single-cycle minute tick from the tick generator.
- load_new_c  in  1  request to load the new_current_time_* digits; level is sampled every cycle.
- new_current_time_ms_hr  in  4  BCD hour tens digit to load.
- new_current_time_ls_hr  in  4  BCD hour units digit to load.
- new_current_time_ms_min  in  4  BCD minute tens digit to load.
- new_current_time_ls_min  in  4  BCD minute units digit to load.
- current_time_ms_hr  out  4  current hour tens digit.
- current_time_ls_hr  out  4  current hour units digit.
- current_time_ms_min  out  4  current minute tens digit.
- current_time_ls_min  out  4  current minute units digit.
- reset_count  out  1  drives the tick generator's reset_count input.
- day_rollover  out  1  one-cycle pulse on the 23:59 -> 00:00 transition.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) gives:
  - all time digits = 0, i.e. 00:00;
  - reset_count = 0, day_rollover = 0, load_err = 0;
  - pulse-stretch counter cleared.
- Load validity (only when LOAD_CHECK=1). A load is valid iff all of:
  - ms_hr <= 2;
  - ls_hr <= 9, and ls_hr <= 3 when ms_hr == 2;
  - ms_min <= 5;
  - ls_min <= 9.
- Valid load at edge N:
  - digits equal the loaded value from N+1;
  - reset_count is high for TICK_CLR_LEN cycles starting at N+1;
  - no increment is applied in cycle N.
- Invalid load at edge N:
  - time is held;
  - load_err = 1 at N+1 for one cycle;
  - reset_count is not asserted.
- load_new_c held high for several cycles: each cycle is treated as a fresh load. Time stays at the loaded value, and reset_count re-arms (stays high) until TICK_CLR_LEN cycles after load_new_c drops.
- Tick with no load at edge N: increment applied, visible at N+1.
  - ls_min 0..9 wraps to 0 and carries into ms_min.
  - ms_min 0..5 wraps to 0 and carries into the hour.
  - Hour counts 00..23, then wraps to 00.
- 23:59 plus tick -> 00:00, and day_rollover = 1 at N+1 for one cycle.
- Simultaneous tick and load: load wins and the tick is discarded. An invalid load also discards the tick; a dropped minute is acceptable because the user is setting the time.
- Ticks arriving while reset_count is high are counted normally. The tick generator suppresses them itself.
- Reset mid-pulse: reset_count drops at the next edge and the stretch counter clears.
- No internal state other than the digit registers and the pulse-stretch counter. The block needs no FSM beyond the pulse stretcher, which is IDLE / CLR(n).

Decomposition:
- Shared package aclk_pkg holds:
  - BCD digit width (4);
  - limits MAX_HR_MS=2, MAX_HR_LS_AT_2=3, MAX_MIN_MS=5, MAX_DIGIT=9.
- One natural sub-module, aclk_bcd_digit:
  - a single BCD digit counter with a wrap limit input;
  - ports: increment enable, synchronous load, carry-out.
  - Instantiated four times. The hour-units limit is selected from the hour-tens value (3 when tens==2, else 9).
- Validity check and pulse stretcher stay in the top level.

Test Plan:
- Reset low for 2 cycles, then high -> digits 00:00; reset_count, day_rollover and load_err all 0.
- Load 12:58, then 2 one_minute ticks 10 cycles apart -> 12:59, then 13:00. reset_count high exactly 1 cycle, the cycle after the load.
- Load 23:59, then a tick -> 00:00 with day_rollover high for 1 cycle. A second tick -> 00:01 with no rollover.
- Load 24:00, then separately 09:60 (LOAD_CHECK=1) -> time unchanged, load_err pulses once per attempt, reset_count stays 0. Repeat with LOAD_CHECK=0 -> value accepted.
- one_minute and load_new_c in the same cycle with load 07:30, from 07:29 -> result 07:30, not 07:31. reset_count asserted.
- TICK_CLR_LEN=3, load held high 2 cycles, then reset driven low on the 2nd reset_count cycle -> reset_count falls at the next edge and time goes to 00:00.
